// File: rtl/seq_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module      : seq_magnitude_comparator
// Description : Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per
//               cycle MSB-first, signed/unsigned per transaction, valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             g,
    output logic             l,
    output logic             e,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] c_last_idx = CW'(NCHUNK - 1);

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("seq_magnitude_comparator: illegal WIDTH/CHUNK combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_idx;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_g;
    logic             r_l;
    logic             r_e;
    logic             r_busy;

    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;

    // Shifting the current chunk up to the MSB keeps the part-select constant.
    assign w_a_sh    = r_a << (32'(r_idx) * CHUNK);
    assign w_b_sh    = r_b << (32'(r_idx) * CHUNK);
    assign w_a_chunk = w_a_sh[WIDTH-1 -: CHUNK];
    assign w_b_chunk = w_b_sh[WIDTH-1 -: CHUNK];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_g         <= 1'b0;
            r_l         <= 1'b0;
            r_e         <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        // Offset-binary: flipping the sign bit maps signed order onto unsigned order.
                        r_a        <= a ^ {signed_mode, {(WIDTH-1){1'b0}}};
                        r_b        <= b ^ {signed_mode, {(WIDTH-1){1'b0}}};
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_a_chunk > w_b_chunk) begin
                        r_g         <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (w_a_chunk < w_b_chunk) begin
                        r_l         <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_idx == c_last_idx) begin
                        r_e         <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_g         <= 1'b0;
                        r_l         <= 1'b0;
                        r_e         <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_g         <= 1'b0;
                    r_l         <= 1'b0;
                    r_e         <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign g         = r_g;
    assign l         = r_l;
    assign e         = r_e;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_magnitude_comparator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seq_magnitude_comparator
// Description : Self-checking bench driving four comparator configurations
//               in lockstep with a per-instance scoreboard of g/l/e + latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_magnitude_comparator;

    localparam int N = 4;

    typedef struct {
        logic eg;
        logic el;
        logic ee;
        int   acc;
        int   k;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic        eg;
        logic        el;
        logic        ee;
        int          k;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          sm = 1'b0;
    logic [15:0]   ta = '0;
    logic [15:0]   tb_b = '0;
    logic [N-1:0]  ir, ov, gg, ll, ee, bz;
    logic [N-1:0]  ordy = '1;
    bit            auto_ordy = 1'b0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[N][$];
    logic [N-1:0] seen = '0;
    int   first_cyc[N];
    exp_t mx;

    function automatic int w_of(input int i);
        return (i == 3) ? 12 : 16;
    endfunction

    function automatic int c_of(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 16;
            default: return 3;
        endcase
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < N; i++) begin : g_dut
        localparam int W = (i == 3) ? 12 : 16;
        localparam int C = (i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 16 : 3;
        seq_magnitude_comparator #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (ir[i]),
            .a          (ta[W-1:0]),
            .b          (tb_b[W-1:0]),
            .signed_mode(sm),
            .out_valid  (ov[i]),
            .out_ready  (ordy[i]),
            .g          (gg[i]),
            .l          (ll[i]),
            .e          (ee[i]),
            .busy       (bz[i])
        );
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] @cyc %0d: got %0h expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    // Reference: direct integer compare; latency from the first differing chunk of a^b.
    function automatic exp_t model(input logic [15:0] a_, input logic [15:0] b_, input logic s_,
                                   input int w, input int c);
        exp_t r;
        int   sa, sb, x, n;
        bit   found;
        sa = int'(a_) & ((1 << w) - 1);
        sb = int'(b_) & ((1 << w) - 1);
        if (s_) begin
            if (sa >= (1 << (w - 1))) sa = sa - (1 << w);
            if (sb >= (1 << (w - 1))) sb = sb - (1 << w);
        end
        r.eg = (sa > sb);
        r.el = (sa < sb);
        r.ee = (sa == sb);
        x = int'(a_ ^ b_) & ((1 << w) - 1);
        n = w / c;
        r.k = n;
        found = 1'b0;
        for (int j = 0; j < n; j++) begin
            if (!found && (((x >> (w - (j + 1) * c)) & ((1 << c) - 1)) != 0)) begin
                r.k = j + 1;
                found = 1'b1;
            end
        end
        r.acc = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) sbq[i].delete();
            seen = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!ov[i]) begin
                    chk("glE_zero_when_invalid", i, 32'({gg[i], ll[i], ee[i]}), 32'd0);
                end else begin
                    chk("onehot", i, 32'($countones({gg[i], ll[i], ee[i]})), 32'd1);
                    if (!seen[i]) begin
                        seen[i] = 1'b1;
                        first_cyc[i] = cyc;
                    end
                    if (ordy[i]) begin
                        if (sbq[i].size() == 0) begin
                            chk("spurious_out_valid", i, 32'd1, 32'd0);
                        end else begin
                            mx = sbq[i].pop_front();
                            chk("result_gle", i, 32'({gg[i], ll[i], ee[i]}), 32'({mx.eg, mx.el, mx.ee}));
                            chk("latency", i, 32'(first_cyc[i] - mx.acc), 32'(mx.k));
                        end
                        seen[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_ordy) begin
            for (int i = 0; i < N; i++) ordy[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (ir != '1 && t < 300) begin
            tick();
            t++;
        end
        if (ir != '1) chk("wait_idle_timeout", -1, 32'(ir), 32'({N{1'b1}}));
    endtask

    task automatic start(input vec_t v, input bit use_tbl);
        exp_t x;
        wait_idle();
        ta = v.a;
        tb_b = v.b;
        sm = v.s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("accept_drops_in_ready", -1, 32'(ir), 32'd0);
        for (int i = 0; i < N; i++) begin
            x = model(v.a, v.b, v.s, w_of(i), c_of(i));
            x.acc = cyc;
            if (i == 0 && use_tbl) begin
                x.eg = v.eg;
                x.el = v.el;
                x.ee = v.ee;
                x.k  = v.k;
            end
            sbq[i].push_back(x);
        end
        // Post-accept operand changes must not affect the result.
        ta = 16'($urandom);
        tb_b = 16'($urandom);
        sm = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        int pend;
        pend = 1;
        while (pend != 0 && t < 300) begin
            tick();
            t++;
            pend = 0;
            for (int i = 0; i < N; i++) pend += sbq[i].size();
        end
        if (pend != 0) begin
            chk("drain_timeout", -1, 32'(pend), 32'd0);
            for (int i = 0; i < N; i++) sbq[i].delete();
        end
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        // Expected values for the 16-bit / 4-bit-chunk instance.
        tbl[0] = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[1] = '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[2] = '{16'h1235, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        tbl[3] = '{16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 4};
        tbl[4] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 4};
        tbl[5] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[6] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[7] = '{16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[8] = '{16'h1200, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 3};
        tbl[9] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 3};

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_out_valid", -1, 32'(ov), 32'd0);
        chk("reset_gle", -1, 32'(gg | ll | ee), 32'd0);
        chk("reset_busy", -1, 32'(bz), 32'd0);
        rst = 1'b0;
        tick();
        chk("reset_in_ready", -1, 32'(ir), 32'({N{1'b1}}));

        for (int v = 0; v < 10; v++) begin
            start(tbl[v], 1'b1);
            drain();
        end

        // Backpressure hold in DONE with new operands offered.
        ordy = '0;
        start(tbl[0], 1'b1);
        begin
            int t = 0;
            while (ov != '1 && t < 40) begin
                tick();
                t++;
            end
            chk("reach_done", -1, 32'(ov), 32'({N{1'b1}}));
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            ta = 16'($urandom);
            tb_b = 16'($urandom);
            tick();
            chk("hold_out_valid", 0, 32'(ov[0]), 32'd1);
            chk("hold_gle", 0, 32'({gg[0], ll[0], ee[0]}), 32'b010);
            chk("hold_in_ready", 0, 32'(ir[0]), 32'd0);
            chk("hold_busy", 0, 32'(bz[0]), 32'd1);
        end
        in_valid = 1'b0;
        ordy = '1;
        tick();
        chk("release_in_ready", -1, 32'(ir), 32'({N{1'b1}}));
        chk("release_out_valid", -1, 32'(ov), 32'd0);
        drain();

        // Reset while the 4-bit instance is at chunk index 2.
        rv = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 4};
        start(rv, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", -1, 32'(ov), 32'd0);
        chk("abort_gle", -1, 32'(gg | ll | ee), 32'd0);
        chk("abort_busy", -1, 32'(bz), 32'd0);
        chk("abort_in_ready", -1, 32'(ir), 32'({N{1'b1}}));
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("abort_no_result", -1, 32'(ov), 32'd0);
        end

        auto_ordy = 1'b1;
        for (int n = 0; n < 2500; n++) begin
            rv.a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rv.b = rv.a;
                1:       rv.b = rv.a ^ (16'h1 << $urandom_range(0, 15));
                default: rv.b = 16'($urandom);
            endcase
            rv.s = 1'($urandom);
            start(rv, 1'b0);
            drain();
        end
        auto_ordy = 1'b0;
        ordy = '1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
